// File: rtl/alu_mdu.sv
// Combinational ALU plus an iterative multiply/divide unit with HI/LO registers.
// The MDU spends WIDTH cycles in RUN, one shift-add or restoring-subtract step per cycle.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] imme,
    input  logic             alu_src,
    input  logic [3:0]       alu_control,
    input  logic [SHW-1:0]   shamt,
    input  logic             equal_branch,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_sig,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             md_cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic [WIDTH-1:0] w_b;

    always_comb begin
        w_b        = alu_src ? imme : data_b;
        alu_result = '0;
        case (alu_control)
            4'b0010: alu_result = data_a + w_b;
            4'b0110: alu_result = data_a - w_b;
            4'b0000: alu_result = data_a & w_b;
            4'b0001: alu_result = data_a | w_b;
            4'b0011: alu_result = data_a ^ w_b;
            4'b1100: alu_result = ~(data_a | w_b);
            4'b0111: alu_result = {{(WIDTH-1){1'b0}}, $signed(data_a) < $signed(w_b)};
            4'b1000: alu_result = {{(WIDTH-1){1'b0}}, data_a < w_b};
            4'b1101: alu_result = w_b << shamt;
            4'b1110: alu_result = w_b >> shamt;
            4'b1111: alu_result = WIDTH'($signed(w_b) >>> shamt);
            4'b1001: alu_result = w_b << (WIDTH/2);
            default: alu_result = '0;
        endcase
        zero_sig = equal_branch ? (alu_result == '0) : (alu_result != '0);
    end

    // MDU state: r_acc holds {partial product, multiplier} or {remainder, quotient}
    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mc, r_a, r_hi, r_lo;
    logic               r_div, r_neg, r_nega, r_bz;
    logic               w_accept, w_fin;

    logic               w_sgn;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_sum, w_sh, w_diff;
    logic [2*WIDTH-1:0] w_acc_nxt, w_prod;
    logic [WIDTH-1:0]   w_q, w_r, w_res_hi, w_res_lo;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            S_RUN: begin
                if (md_cancel)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == CW'(WIDTH-1)) begin
                    w_state_nxt = S_DONE;
                    w_fin       = 1'b1;
                end
            end
            default: begin
                if (md_start && !md_cancel) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end else
                    w_state_nxt = S_IDLE;
            end
        endcase
        md_busy = (r_state == S_RUN);
        md_done = (r_state == S_DONE);
    end

    always_comb begin
        w_sgn   = ~md_op[0];
        w_mag_a = (w_sgn && data_a[WIDTH-1]) ? ('0 - data_a) : data_a;
        w_mag_b = (w_sgn && data_b[WIDTH-1]) ? ('0 - data_b) : data_b;

        w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mc} : '0);
        w_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_diff = w_sh - {1'b0, r_mc};
        if (!r_div)
            w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        else if (w_diff[WIDTH])
            w_acc_nxt = {w_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        else
            w_acc_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

        w_prod = r_neg ? ('0 - w_acc_nxt) : w_acc_nxt;
        w_q    = r_neg  ? ('0 - w_acc_nxt[WIDTH-1:0]) : w_acc_nxt[WIDTH-1:0];
        w_r    = r_nega ? ('0 - w_acc_nxt[2*WIDTH-1:WIDTH]) : w_acc_nxt[2*WIDTH-1:WIDTH];

        if (!r_div) begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end else if (r_bz) begin
            w_res_hi = r_a;
            w_res_lo = '1;
        end else begin
            w_res_hi = w_r;
            w_res_lo = w_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_mc   <= '0;
            r_a    <= '0;
            r_div  <= 1'b0;
            r_neg  <= 1'b0;
            r_nega <= 1'b0;
            r_bz   <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mc   <= w_mag_b;
            r_a    <= data_a;
            r_div  <= md_op[1];
            r_neg  <= w_sgn & (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
            r_nega <= w_sgn & data_a[WIDTH-1];
            r_bz   <= (data_b == '0);
        end else if (r_state == S_RUN && !md_cancel) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Software writes are held off for the single cycle the fresh result is shown
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == S_RUN) begin
            if (w_fin) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (r_state == S_IDLE) begin
            if (hi_we) r_hi <= data_a;
            if (lo_we) r_lo <= data_a;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: ALU vectors, MDU latency/results, cancel and reset cases.
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] data_a, data_b, imme;
    logic        alu_src;
    logic [3:0]  alu_control;
    logic [4:0]  shamt;
    logic        equal_branch;
    logic [31:0] alu_result;
    logic        zero_sig;
    logic        md_start;
    logic [1:0]  md_op;
    logic        md_cancel, hi_we, lo_we;
    logic        md_busy, md_done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    int lat, nbusy, ndone;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .data_a(data_a), .data_b(data_b), .imme(imme),
        .alu_src(alu_src), .alu_control(alu_control), .shamt(shamt),
        .equal_branch(equal_branch), .alu_result(alu_result), .zero_sig(zero_sig),
        .md_start(md_start), .md_op(md_op), .md_cancel(md_cancel),
        .hi_we(hi_we), .lo_we(lo_we), .md_busy(md_busy), .md_done(md_done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
        alu_control = op; data_a = a; data_b = b; alu_src = 1'b0;
        #1 chk(tag, alu_result, exp);
    endtask

    // starts at the current time (just after an edge), returns edges until md_done
    task automatic do_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int l, output int nb);
        md_op = op; data_a = a; data_b = b; md_start = 1'b1;
        @(posedge clk); #1 md_start = 1'b0;
        l = 0; nb = 0;
        while (!md_done && l < 40) begin
            if (md_busy) nb++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        resetn = 1'b0; data_a = '0; data_b = '0; imme = '0; alu_src = 1'b0;
        alu_control = 4'b0000; shamt = '0; equal_branch = 1'b0;
        md_start = 1'b0; md_op = 2'b00; md_cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        #2;
        chk("rst_busy", md_busy, 0);
        chk("rst_done", md_done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(posedge clk); @(posedge clk); #1 resetn = 1'b1;

        // ALU
        shamt = 5'd4;
        alu(4'b1111, 32'h0, 32'h8000_0000, 32'hF800_0000, "sra");
        alu(4'b1110, 32'h0, 32'h8000_0000, 32'h0800_0000, "srl");
        alu(4'b1101, 32'h0, 32'h0000_0011, 32'h0000_0110, "sll");
        alu(4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, "slt");
        alu(4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h0, "sltu");
        alu(4'b0010, 32'hFFFF_FFFF, 32'h2, 32'h1, "add_wrap");
        alu(4'b0011, 32'hF0F0_1234, 32'h0FF0_0234, 32'hFF00_1000, "xor");
        alu(4'b1100, 32'hF0F0_0000, 32'h0000_000F, 32'h0F0F_FFF0, "nor");
        alu(4'b0100, 32'h1234_5678, 32'h1, 32'h0, "undef_op");
        equal_branch = 1'b1;
        alu(4'b0110, 32'h5, 32'h5, 32'h0, "sub55");
        chk("zero_eq1", zero_sig, 1);
        equal_branch = 1'b0;
        #1 chk("zero_eq0", zero_sig, 0);
        alu_control = 4'b1001; alu_src = 1'b1; imme = 32'h0000_1234; data_b = 32'hDEAD_BEEF;
        #1 chk("lui", alu_result, 32'h1234_0000);
        alu_src = 1'b0;

        // MDU
        @(posedge clk); #1;
        do_md(2'b00, 32'hFFFF_FFFF, 32'h2, lat, nbusy);
        chk("mult_lat", lat, 32);
        chk("mult_busy", nbusy, 32);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk); #1;
        chk("done_pulse", md_done, 0);
        chk("idle_busy", md_busy, 0);
        do_md(2'b01, 32'hFFFF_FFFF, 32'h2, lat, nbusy);
        chk("multu_lat", lat, 32);
        chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        // back-to-back start straight out of DONE
        do_md(2'b10, 32'hFFFF_FFF9, 32'h2, lat, nbusy);
        chk("div_lat", lat, 32);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        @(posedge clk); #1;
        do_md(2'b11, 32'h7, 32'h2, lat, nbusy);
        chk("divu_hilo", {hi, lo}, 64'h0000_0001_0000_0003);
        @(posedge clk); #1;
        do_md(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, nbusy);
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        @(posedge clk); #1;
        do_md(2'b10, 32'h5, 32'h0, lat, nbusy);
        chk("div0_lat", lat, 32);
        chk("div0_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        @(posedge clk); #1;
        do_md(2'b10, 32'hFFFF_FFF9, 32'h0, lat, nbusy);
        chk("div0_neg", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);

        // cancel: preload HI, start mult, poke hi_we and md_start mid-run, cancel at cycle 10
        @(posedge clk); #1;
        hi_we = 1'b1; data_a = 32'hA5A5_A5A5;
        @(posedge clk); #1 hi_we = 1'b0;
        chk("hi_we", hi, 32'hA5A5_A5A5);
        md_op = 2'b00; data_a = 32'h3; data_b = 32'h4; md_start = 1'b1;
        @(posedge clk); #1 md_start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (i == 4) begin hi_we = 1'b1; data_a = 32'h1111_1111; end
            if (i == 6) begin hi_we = 1'b0; md_start = 1'b1; end
            if (i == 7) md_start = 1'b0;
            @(posedge clk); #1;
        end
        chk("busy_c10", md_busy, 1);
        md_cancel = 1'b1;
        @(posedge clk); #1 md_cancel = 1'b0;
        chk("cancel_busy", md_busy, 0);
        chk("cancel_hi", hi, 32'hA5A5_A5A5);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_done) ndone++;
            @(posedge clk); #1;
        end
        chk("cancel_nodone", ndone, 0);
        md_start = 1'b1; md_cancel = 1'b1;
        @(posedge clk); #1 md_start = 1'b0; md_cancel = 1'b0;
        chk("startcancel_busy", md_busy, 0);
        @(posedge clk); #1;
        chk("startcancel_done", md_done, 0);

        // reset mid-divide
        md_op = 2'b10; data_a = 32'd100; data_b = 32'd7; md_start = 1'b1;
        @(posedge clk); #1 md_start = 1'b0;
        for (int i = 1; i < 15; i++) begin @(posedge clk); #1; end
        chk("busy_c15", md_busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", md_busy, 0);
        chk("arst_done", md_done, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        @(posedge clk); #1 resetn = 1'b1;
        do_md(2'b01, 32'h3, 32'h4, lat, nbusy);
        chk("post_rst_lat", lat, 32);
        chk("post_rst_multu", {hi, lo}, 64'h0000_0000_0000_000C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (even, >= 8).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 data_a  input  WIDTH  operand A; also HI/LO write data.
REQ-006 data_b  input  WIDTH  operand B (register).
REQ-007 imme  input  WIDTH  immediate operand B.
REQ-008 alu_src  input  1  1 = B is imme, 0 = B is data_b.
REQ-009 alu_control  input  4  ALU opcode.
REQ-010 shamt  input  SHW  shift amount.
REQ-011 equal_branch  input  1  selects zero_sig polarity.
REQ-012 alu_result  output  WIDTH  combinational ALU result.
REQ-013 zero_sig  output  1  branch condition.
REQ-014 md_start  input  1  start multiply/divide; sampled on rising edge.
REQ-015 md_op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-016 md_cancel  input  1  abort in-flight operation (pipeline flush).
REQ-017 hi_we, lo_we  input  1 each  write data_a into HI/LO.
REQ-018 md_busy  output  1  operation in progress.
REQ-019 md_done  output  1  one-cycle completion pulse.
REQ-020 hi, lo  output  WIDTH each  HI/LO register contents.

Function
REQ-021 ALU path SHALL be combinational with B = alu_src ? imme : data_b.
REQ-022 Opcodes: 0010 add, 0110 sub, 0000 and, 0001 or, 0011 xor, 1100 nor, 0111 slt (signed), 1000 sltu, 1101 sll B by shamt, 1110 srl B, 1111 sra B, 1001 lui (B << WIDTH/2); others SHALL give 0.
REQ-023 add/sub SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-024 zero_sig SHALL be (alu_result == 0) when equal_branch = 1, else (alu_result != 0).
REQ-025 MDU SHALL be a 3-state FSM: IDLE, RUN, DONE.
REQ-026 IDLE/DONE + md_start & !md_cancel -> RUN; latch data_a, data_b (never imme) and md_op; clear iteration counter.
REQ-027 RUN SHALL perform one shift-add (mult) or restoring-subtract (div) step per cycle on magnitudes, WIDTH steps total.
REQ-028 After step WIDTH, the same edge SHALL load HI/LO and enter DONE; result visible exactly WIDTH cycles after the start edge.
REQ-029 DONE SHALL last one cycle -> IDLE unless a new md_start is accepted (back-to-back allowed).
REQ-030 md_busy = 1 only in RUN; md_done = 1 only in DONE.
REQ-031 mult/multu: {HI,LO} = 2*WIDTH-bit product, signed or unsigned.
REQ-032 div/divu: LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-033 Divide by zero (any sign): LO = all ones, HI = dividend; still WIDTH cycles.
REQ-034 Signed most-negative / -1: LO = most-negative, HI = 0.
REQ-035 md_start while in RUN SHALL be ignored.
REQ-036 md_cancel in RUN -> IDLE next edge, HI/LO unchanged, no md_done; md_cancel wins over same-cycle md_start.
REQ-037 hi_we/lo_we SHALL update HI/LO next edge only when not in RUN; ignored in RUN; in DONE the MDU result takes priority.

Reset
REQ-038 resetn low SHALL immediately force IDLE, counter 0, HI = 0, LO = 0, md_busy = 0, md_done = 0, discarding any operation in progress.
REQ-039 After resetn deasserts, first md_start SHALL be accepted on the first rising edge.

Verification
REQ-040 WIDTH=32, mult 0xFFFFFFFF x 2 -> HI=FFFFFFFF, LO=FFFFFFFE; multu same -> HI=00000001, LO=FFFFFFFE; md_done exactly 32 cycles after start edge, busy high 32 cycles.
REQ-041 div -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF; divu 7/2 -> LO=3, HI=1; div 0x80000000/0xFFFFFFFF -> LO=80000000, HI=0.
REQ-042 div 5/0 -> LO=FFFFFFFF, HI=00000005, md_done after 32 cycles.
REQ-043 Preload HI=A5A5A5A5 via hi_we, start mult, md_cancel at cycle 10 -> busy low next edge, HI still A5A5A5A5, no md_done; start+cancel together in IDLE -> stays IDLE.
REQ-044 Assert resetn low at cycle 15 of a divide -> busy, done, HI, LO all 0 before next edge; new multu 3x4 after release -> LO=0000000C.
REQ-045 ALU: sra 0x80000000 by 4 -> F8000000; A=FFFFFFFF, B=1: slt -> 1, sltu -> 0; sub 5-5 with equal_branch=1 -> zero_sig 1, equal_branch=0 -> 0; lui imme=0x1234 -> 12340000.
